// File: rtl/row_scanner.sv
// row_scanner: drives a one-hot (or two-hot when binning) line select that
// walks from start_line to stop_line in increments of step, holding each line
// for dwell+1 cycles. A one-cycle done pulse marks normal completion and a
// one-cycle err pulse marks a rejected start request.
//
// Handshake: start is a level sampled only while the scanner is idle. There is
// no ready signal. A start issued in IDLE is either accepted, so that busy rises
// on the next cycle, or rejected, so that err pulses on the next cycle. A start
// issued at any other time is dropped. abort takes precedence over everything
// else.
module row_scanner #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8,
    localparam int IDX_W  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W-1:0]   start_line,
    input  logic [IDX_W-1:0]   stop_line,
    input  logic [IDX_W-1:0]   step,
    input  logic               bin,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   out,
    output logic [IDX_W-1:0]   line_idx,
    output logic               line_strobe,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Highest legal line index, one bit wider so the range check cannot wrap.
    localparam logic [IDX_W:0] MAX_LINE = (IDX_W+1)'(WIDTH - 1);

    // Registered state.
    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   sel_q,    sel_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [DWELL_W-1:0] cnt_q,    cnt_d;
    logic               strobe_q, strobe_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;

    // Configuration captured when a scan is accepted.
    logic [IDX_W-1:0]   start_q, start_d;
    logic [IDX_W-1:0]   stop_q,  stop_d;
    logic [IDX_W-1:0]   step_q,  step_d;
    logic               bin_q,   bin_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // Helper terms.
    logic               cfg_ok;
    logic [IDX_W-1:0]   step_eff;
    logic [IDX_W:0]     next_line;
    logic               last_cycle_of_line;

    // Select pattern for a line. With binning the neighbour above is also set,
    // except on the top line, where there is no wrap back to line 0.
    function automatic logic [WIDTH-1:0] line_mask(input logic [IDX_W-1:0] idx,
                                                   input logic             two);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(idx) || (two && (i == int'(idx) + 1))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // A request is legal when the range is ordered and stays on the array.
    assign cfg_ok = ({1'b0, start_line} <= {1'b0, stop_line}) &&
                    ({1'b0, stop_line} <= MAX_LINE);

    // A step of zero would stall the scan, so it is treated as one.
    assign step_eff = (step_q == '0) ? IDX_W'(1) : step_q;

    // The next line is computed one bit wider so overshooting the top ends the scan.
    assign next_line = {1'b0, idx_q} + {1'b0, step_eff};

    assign last_cycle_of_line = (cnt_q == dwell_q);

    // Next-state and next-output logic for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        bin_d    = bin_q;
        dwell_d  = dwell_q;

        case (state_q)
            S_IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                // abort while idle does nothing except swallow a same-cycle start.
                if (start && !abort) begin
                    if (cfg_ok) begin
                        start_d  = start_line;
                        stop_d   = stop_line;
                        step_d   = step;
                        bin_d    = bin;
                        dwell_d  = dwell;
                        state_d  = S_SCAN;
                        idx_d    = start_line;
                        sel_d    = line_mask(start_line, bin);
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SCAN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (last_cycle_of_line) begin
                    if (next_line > {1'b0, stop_q}) begin
                        // Past the last permitted line: finish, keep line_idx.
                        state_d = S_DONE;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        idx_d    = next_line[IDX_W-1:0];
                        sel_d    = line_mask(next_line[IDX_W-1:0], bin_q);
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end

            S_DONE: begin
                // Single-cycle state: always returns to IDLE. An abort here
                // lands in the same place.
                state_d = S_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            bin_q    <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            bin_q    <= bin_d;
            dwell_q  <= dwell_d;
        end
    end

    // enable only masks the pins. The scan keeps running underneath.
    assign out         = enable ? sel_q : '0;
    assign line_idx    = idx_q;
    assign line_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_row_scanner.sv
// Directed bench for row_scanner (WIDTH=8, DWELL_W=8). Expected values are
// written out by hand from the scan rules. Outputs are sampled 1ns after the
// rising edge.
module tb_row_scanner;

    localparam int WIDTH   = 8;
    localparam int DWELL_W = 8;
    localparam int IDX_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               start;
    logic               abort;
    logic [IDX_W-1:0]   start_line;
    logic [IDX_W-1:0]   stop_line;
    logic [IDX_W-1:0]   step;
    logic               bin;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   out;
    logic [IDX_W-1:0]   line_idx;
    logic               line_strobe;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         state_dbg;

    int checks = 0;
    int errors = 0;

    row_scanner #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .abort       (abort),
        .start_line  (start_line),
        .stop_line   (stop_line),
        .step        (step),
        .bin         (bin),
        .dwell       (dwell),
        .out         (out),
        .line_idx    (line_idx),
        .line_strobe (line_strobe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                             input logic e_strobe, input logic e_busy, input logic e_done,
                             input logic e_err);
        chk({tag, ".out"},    32'(out),         32'(e_out));
        chk({tag, ".idx"},    32'(line_idx),    32'(e_idx));
        chk({tag, ".strobe"}, 32'(line_strobe), 32'(e_strobe));
        chk({tag, ".busy"},   32'(busy),        32'(e_busy));
        chk({tag, ".done"},   32'(done),        32'(e_done));
        chk({tag, ".err"},    32'(err),         32'(e_err));
    endtask

    task automatic set_cfg(input logic [2:0] s_line, input logic [2:0] e_line,
                           input logic [2:0] st, input logic b, input logic [7:0] dw);
        start_line = s_line;
        stop_line  = e_line;
        step       = st;
        bin        = b;
        dwell      = dw;
    endtask

    // Directed stimulus and checks
    initial begin
        logic [7:0] e_out;
        logic [2:0] e_idx;

        reset  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        set_cfg(3'd0, 3'd0, 3'd0, 1'b0, 8'd0);

        // Reset state
        tick();
        tick();
        chk_cycle("rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.state", 32'(state_dbg), 32'(ST_IDLE));

        // First start is taken on the first edge after reset is released.
        reset = 1'b1;
        set_cfg(3'd2, 3'd5, 3'd1, 1'b0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("basic.c1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic.state", 32'(state_dbg), 32'(ST_SCAN));
        tick();
        chk_cycle("basic.c2", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cycle("basic.c3", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cycle("basic.c4", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cycle("basic.done", 8'h00, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic.dstate", 32'(state_dbg), 32'(ST_DONE));
        tick();
        chk_cycle("basic.idle", 8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("basic.istate", 32'(state_dbg), 32'(ST_IDLE));

        // Step 3, dwell 2. Config changes and a restart mid-scan are ignored.
        set_cfg(3'd1, 3'd7, 3'd3, 1'b0, 8'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            e_idx = (c <= 3) ? 3'd1 : ((c <= 6) ? 3'd4 : 3'd7);
            e_out = 8'h01 << e_idx;
            chk_cycle($sformatf("step3.c%0d", c), e_out, e_idx, (c % 3) == 1, 1'b1, 1'b0, 1'b0);
            if (c == 2) begin
                set_cfg(3'd0, 3'd2, 3'd1, 1'b1, 8'd0);
                start = 1'b1;
            end
            if (c == 5) start = 1'b0;
            tick();
        end
        chk_cycle("step3.done", 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Binning at the top edge, with step 1 and again with step 0.
        for (int s = 0; s < 2; s++) begin
            set_cfg(3'd6, 3'd7, (s == 0) ? 3'd1 : 3'd0, 1'b1, 8'd0);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk_cycle($sformatf("bin%0d.c1", s), 8'hC0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            chk_cycle($sformatf("bin%0d.c2", s), 8'h80, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            chk_cycle($sformatf("bin%0d.done", s), 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end

        // An inverted range is rejected with a single err pulse.
        set_cfg(3'd5, 3'd3, 3'd1, 1'b0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("rej.c1", 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rej.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk_cycle("rej.c2", 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-line scan on line 0.
        set_cfg(3'd0, 3'd0, 3'd1, 1'b0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("one.c1", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cycle("one.done", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // enable low masks out while the scan continues, then abort on line 3.
        set_cfg(3'd0, 3'd7, 3'd1, 1'b0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("en.c1", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        tick();
        chk_cycle("en.c2", 8'h00, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_cycle("en.c3", 8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        chk_cycle("en.c4", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_cycle("abort.c1", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        chk_cycle("abort.c2", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // An abort while idle swallows a same-cycle start.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_cycle("idleabort", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan clears everything before the next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_cycle("mid.c2", 8'h02, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk_cycle("mid.rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid.state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_cycle($sformatf("post.c%0d", c), 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
